// File: rtl/op_fetch.sv
// Purpose: fetch/latch stage that turns program-memory words into an 8-bit key plus a 16-bit operand for the Mux8 chain.
// Latency: short form presents on the edge after the opcode transfer; long form on the edge after the operand transfer.
// Backpressure: mem_ready drops while an instruction is held; it stays held until out_ack, giving a one-cycle bubble per issue.
module op_fetch #(
    parameter logic [7:0] IDLE_KEY = 8'hFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] mem_word,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic        flush,
    output logic [7:0]  key,
    output logic [15:0] data_out,
    output logic        out_valid,
    input  logic        out_ack,
    output logic [15:0] issue_count
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_FETCH_OP  = 2'd1,
        S_FETCH_ARG = 2'd2,
        S_HOLD      = 2'd3
    } state_t;

    state_t      r_state;
    logic [7:0]  r_key;
    logic [7:0]  r_opcode;
    logic [15:0] r_data;
    logic [15:0] r_issue_count;

    logic        w_xfer;
    logic        w_issue;

    // Handshake flags come from the registered state only, so no input reaches them combinationally.
    assign mem_ready   = (r_state == S_FETCH_OP) || (r_state == S_FETCH_ARG);
    assign out_valid   = (r_state == S_HOLD);
    assign w_xfer      = mem_valid && mem_ready;
    // An ack that coincides with flush is an abort, not an issue.
    assign w_issue     = (r_state == S_HOLD) && out_ack && !flush;

    assign key         = r_key;
    assign data_out    = r_data;
    assign issue_count = r_issue_count;

    // Fetch FSM with registered key/operand; flush overrides any transfer or ack on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_key    <= IDLE_KEY;
            r_data   <= 16'h0000;
            r_opcode <= 8'h00;
        end else if (flush) begin
            r_state  <= S_FETCH_OP;
            r_key    <= IDLE_KEY;
            r_data   <= 16'h0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_FETCH_OP;
                end
                S_FETCH_OP: begin
                    if (w_xfer) begin
                        if (mem_word[7]) begin
                            // Long form: upper byte of the opcode word is unused.
                            r_opcode <= mem_word[7:0];
                            r_state  <= S_FETCH_ARG;
                        end else begin
                            r_key   <= mem_word[7:0];
                            r_data  <= {8'h00, mem_word[15:8]};
                            r_state <= S_HOLD;
                        end
                    end
                end
                S_FETCH_ARG: begin
                    if (w_xfer) begin
                        r_key   <= r_opcode;
                        r_data  <= mem_word;
                        r_state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    // key/data_out stay frozen until the consumer acknowledges.
                    if (out_ack) begin
                        r_key   <= IDLE_KEY;
                        r_data  <= 16'h0000;
                        r_state <= S_FETCH_OP;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Issue counter; wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issue_count <= 16'h0000;
        end else begin
            r_issue_count <= r_issue_count + {15'd0, w_issue};
        end
    end

endmodule

// File: tb/tb_op_fetch.sv
// Purpose: directed self-checking bench for op_fetch with a scoreboard of expected {key, data_out}.
// Latency: instructions are compared the cycle they are presented.
// Backpressure: out_ack is driven explicitly per step.
module tb_op_fetch;

    logic        clk;
    logic        rst_n;
    logic [15:0] mem_word;
    logic        mem_valid;
    logic        mem_ready;
    logic        flush;
    logic [7:0]  key;
    logic [15:0] data_out;
    logic        out_valid;
    logic        out_ack;
    logic [15:0] issue_count;

    int          errors;
    int          checks;
    logic [15:0] exp_count;
    logic [23:0] sb[$];
    logic [23:0] cur;
    logic [15:0] tp_words[4];

    op_fetch #(.IDLE_KEY(8'hFF)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_word   (mem_word),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .flush      (flush),
        .key        (key),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .out_ack    (out_ack),
        .issue_count(issue_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Wait (bounded) for a presented instruction and compare it with the scoreboard head.
    task automatic expect_instr(input string tag);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        cur = (sb.size() > 0) ? sb.pop_front() : 24'hxxxxxx;
        chk({tag, "_key"},  {24'd0, key},      {24'd0, cur[23:16]});
        chk({tag, "_data"}, {16'd0, data_out}, {16'd0, cur[15:0]});
    endtask

    task automatic ack_one();
        out_ack = 1'b1;
        step();
        out_ack = 1'b0;
        exp_count = exp_count + 16'd1;
    endtask

    task automatic chk_idle_out(input string tag);
        chk({tag, "_key"},   {24'd0, key},      32'h0000_00FF);
        chk({tag, "_data"},  {16'd0, data_out}, 32'd0);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_count"}, {16'd0, issue_count}, {16'd0, exp_count});
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        exp_count = 16'd0;
        rst_n     = 1'b0;
        mem_word  = 16'h0000;
        mem_valid = 1'b0;
        flush     = 1'b0;
        out_ack   = 1'b0;
        tp_words  = '{16'h1101, 16'h2202, 16'h3303, 16'h4404};

        // Reset state
        step();
        step();
        chk_idle_out("rst");
        chk("rst_ready", {31'd0, mem_ready}, 32'd0);
        rst_n = 1'b1;
        chk("idle_ready", {31'd0, mem_ready}, 32'd0);
        step();
        chk("fetch_ready", {31'd0, mem_ready}, 32'd1);

        // Short form, held for 5 cycles before ack
        mem_word  = 16'h3412;
        mem_valid = 1'b1;
        sb.push_back({8'h12, 16'h0034});
        step();
        mem_valid = 1'b0;
        chk("short_valid_now", {31'd0, out_valid}, 32'd1);
        expect_instr("short");
        for (int i = 0; i < 5; i++) begin
            step();
            chk("short_hold_key",  {24'd0, key},       {24'd0, cur[23:16]});
            chk("short_hold_data", {16'd0, data_out},  {16'd0, cur[15:0]});
            chk("short_hold_vld",  {31'd0, out_valid}, 32'd1);
            chk("short_hold_rdy",  {31'd0, mem_ready}, 32'd0);
        end
        ack_one();
        chk_idle_out("short_ack");

        // Long form with idle cycles between opcode and operand
        mem_word  = 16'hAB85;
        mem_valid = 1'b1;
        step();
        mem_valid = 1'b0;
        chk("long_arg_vld", {31'd0, out_valid}, 32'd0);
        chk("long_arg_key", {24'd0, key}, 32'h0000_00FF);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("long_gap_vld", {31'd0, out_valid}, 32'd0);
            chk("long_gap_rdy", {31'd0, mem_ready}, 32'd1);
        end
        mem_word  = 16'hBEEF;
        mem_valid = 1'b1;
        sb.push_back({8'h85, 16'hBEEF});
        step();
        mem_valid = 1'b0;
        chk("long_valid_now", {31'd0, out_valid}, 32'd1);
        expect_instr("long");
        ack_one();
        chk_idle_out("long_ack");

        // Throughput: back-to-back short forms with ack held high
        for (int i = 0; i < 4; i++)
            sb.push_back({tp_words[i][7:0], 8'h00, tp_words[i][15:8]});
        mem_valid = 1'b1;
        out_ack   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            mem_word = tp_words[i/2];
            step();
            if (i % 2 == 0) begin
                chk("tp_vld_hi", {31'd0, out_valid}, 32'd1);
                chk("tp_rdy_lo", {31'd0, mem_ready}, 32'd0);
                cur = (sb.size() > 0) ? sb.pop_front() : 24'hxxxxxx;
                chk("tp_key",  {24'd0, key},      {24'd0, cur[23:16]});
                chk("tp_data", {16'd0, data_out}, {16'd0, cur[15:0]});
            end else begin
                exp_count = exp_count + 16'd1;
                chk("tp_vld_lo", {31'd0, out_valid}, 32'd0);
                chk("tp_rdy_hi", {31'd0, mem_ready}, 32'd1);
            end
        end
        mem_valid = 1'b0;
        out_ack   = 1'b0;
        chk("tp_count", {16'd0, issue_count}, 32'd6);

        // Flush on the same edge as the long-form operand
        mem_word  = 16'h0081;
        mem_valid = 1'b1;
        step();
        mem_word  = 16'h1111;
        flush     = 1'b1;
        step();
        flush     = 1'b0;
        mem_valid = 1'b0;
        chk_idle_out("flush_arg");
        chk("flush_arg_rdy", {31'd0, mem_ready}, 32'd1);
        step();
        step();
        chk("flush_arg_later_vld", {31'd0, out_valid}, 32'd0);

        // Flush together with ack in HOLD is not counted
        mem_word  = 16'h5607;
        mem_valid = 1'b1;
        sb.push_back({8'h07, 16'h0056});
        step();
        mem_valid = 1'b0;
        expect_instr("flush_hold");
        out_ack = 1'b1;
        flush   = 1'b1;
        step();
        out_ack = 1'b0;
        flush   = 1'b0;
        chk_idle_out("flush_hold");
        chk("flush_hold_rdy", {31'd0, mem_ready}, 32'd1);

        // Counter wrap from 16'hFFFF
        force dut.r_issue_count = 16'hFFFF;
        step();
        release dut.r_issue_count;
        exp_count = 16'hFFFF;
        chk("wrap_pre", {16'd0, issue_count}, 32'h0000_FFFF);
        mem_word  = 16'h0009;
        mem_valid = 1'b1;
        sb.push_back({8'h09, 16'h0000});
        step();
        mem_valid = 1'b0;
        expect_instr("wrap");
        ack_one();
        chk("wrap_count", {16'd0, issue_count}, 32'd0);

        // Asynchronous reset mid-HOLD, between edges
        mem_word  = 16'h7710;
        mem_valid = 1'b1;
        sb.push_back({8'h10, 16'h0077});
        step();
        mem_valid = 1'b0;
        expect_instr("arst");
        #3;
        rst_n = 1'b0;
        #1;
        exp_count = 16'd0;
        chk_idle_out("arst");
        chk("arst_rdy", {31'd0, mem_ready}, 32'd0);
        step();
        rst_n = 1'b1;
        chk("arst_idle_rdy", {31'd0, mem_ready}, 32'd0);
        step();
        chk("arst_fetch_rdy", {31'd0, mem_ready}, 32'd1);
        chk("arst_sb_empty", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
